// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline control for the dual-issue core.
//
// Arbitrates stage stall requests into a 4-bit stall vector, turns MEM-stage
// exceptions/ERET and EX-stage branch mispredictions into a single registered
// one-cycle flush pulse with its cause and redirect PC, defers a misprediction
// while EX is held, and keeps saturating stall/flush performance counters.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stallreq_id/ex/mem/wb  per-stage stall requests
//   exc_valid           MEM-stage exception or ERET commit
//   exc_is_eret         qualifies exc_valid as ERET (redirect to cp0_epc)
//   cp0_epc             ERET return address
//   misp_valid          EX branch misprediction
//   misp_target         corrected fetch address
//   clr_cnt             synchronous clear of both counters
//   stall[3:0]          bit0 ID, bit1 EX, bit2 MEM, bit3 WB; 1 = hold stage
//   flush               one-cycle flush pulse (registered)
//   flush_cause         0 = exception, 1 = failed branch prediction
//   new_pc              redirect address, valid while flush=1
//   stall_cycles        saturating count of cycles with stall[0]=1
//   flush_count         saturating count of flush pulses
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          STALL_CNT_W = 32,
    parameter int          FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   stallreq_wb,
    input  logic                   exc_valid,
    input  logic                   exc_is_eret,
    input  logic [31:0]            cp0_epc,
    input  logic                   misp_valid,
    input  logic [31:0]            misp_target,
    input  logic                   clr_cnt,
    output logic [3:0]             stall,
    output logic                   flush,
    output logic                   flush_cause,
    output logic [31:0]            new_pc,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MISP_PEND = 2'd1,
        ST_FLUSH     = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE = {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic                   flush_cause_q, flush_cause_d;
    logic [31:0]            new_pc_q, new_pc_d;
    logic [31:0]            pend_tgt_q, pend_tgt_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [FLUSH_CNT_W-1:0] flush_count_q, flush_count_d;
    logic [3:0]             stall_req;

    // Highest requesting stage wins; holding a stage also holds everything
    // upstream of it.
    always_comb begin
        stall_req = 4'b0000;
        if (stallreq_wb)       stall_req = 4'b1111;
        else if (stallreq_mem) stall_req = 4'b0111;
        else if (stallreq_ex)  stall_req = 4'b0011;
        else if (stallreq_id)  stall_req = 4'b0001;
    end

    // Stalls are meaningless while the pipe is being squashed or reset.
    assign stall = (rst || state_q == ST_FLUSH) ? 4'b0000 : stall_req;

    always_comb begin
        state_d       = state_q;
        flush_cause_d = flush_cause_q;
        new_pc_d      = new_pc_q;
        pend_tgt_d    = pend_tgt_q;

        case (state_q)
            ST_FLUSH: begin
                // Everything seen during the flush cycle comes from squashed
                // instructions, so it is ignored.
                state_d = ST_IDLE;
            end
            default: begin
                if (exc_valid) begin
                    // Exceptions outrank (and discard) any misprediction.
                    state_d       = ST_FLUSH;
                    flush_cause_d = 1'b0;
                    new_pc_d      = exc_is_eret ? cp0_epc : EXC_VECTOR;
                end else if (state_q == ST_MISP_PEND) begin
                    // Oldest branch wins: new mispredictions are ignored here.
                    if (!stall[1]) begin
                        state_d       = ST_FLUSH;
                        flush_cause_d = 1'b1;
                        new_pc_d      = pend_tgt_q;
                    end
                end else if (misp_valid) begin
                    if (!stall[1]) begin
                        state_d       = ST_FLUSH;
                        flush_cause_d = 1'b1;
                        new_pc_d      = misp_target;
                    end else begin
                        state_d    = ST_MISP_PEND;
                        pend_tgt_d = misp_target;
                    end
                end
            end
        endcase
    end

    // FLUSH always returns to IDLE, so any move into FLUSH is a new pulse.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (clr_cnt) begin
            stall_cycles_d = '0;
            flush_count_d  = '0;
        end else begin
            if (stall[0] && !(&stall_cycles_q))
                stall_cycles_d = stall_cycles_q + STALL_ONE;
            if (state_d == ST_FLUSH && !(&flush_count_q))
                flush_count_d = flush_count_q + FLUSH_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            flush_cause_q  <= 1'b0;
            new_pc_q       <= 32'h0;
            pend_tgt_q     <= 32'h0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            flush_cause_q  <= flush_cause_d;
            new_pc_q       <= new_pc_d;
            pend_tgt_q     <= pend_tgt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign flush        = (state_q == ST_FLUSH);
    assign flush_cause  = flush_cause_q;
    assign new_pc       = new_pc_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed steps followed by random traffic, all
// checked against a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam int SW = 5;
    localparam int FW = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, sid, sex, smem, swb, exc, eret, misp, clr;
    logic [31:0]   epc, mtgt;
    logic [3:0]    stall;
    logic          flush, flush_cause;
    logic [31:0]   new_pc;
    logic [SW-1:0] stall_cycles;
    logic [FW-1:0] flush_count;

    pipe_ctrl #(.EXC_VECTOR(VEC), .STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem), .stallreq_wb(swb),
        .exc_valid(exc), .exc_is_eret(eret), .cp0_epc(epc),
        .misp_valid(misp), .misp_target(mtgt), .clr_cnt(clr),
        .stall(stall), .flush(flush), .flush_cause(flush_cause), .new_pc(new_pc),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: what the outputs must show after each edge.
    bit          m_flush, m_cause, m_pend;
    logic [31:0] m_pc, m_tgt;
    int          m_sc, m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_stall();
        int top;
        top = -1;
        if (sid)  top = 0;
        if (sex)  top = 1;
        if (smem) top = 2;
        if (swb)  top = 3;
        if (rst || m_flush || top < 0) return 4'b0000;
        return 4'((1 << (top + 1)) - 1);
    endfunction

    task automatic step();
        logic [3:0] es;
        bit         go;
        @(negedge clk);
        es = model_stall();
        chk("stall", {28'b0, stall}, {28'b0, es});
        @(posedge clk);
        if (rst) begin
            m_flush = 0; m_cause = 0; m_pend = 0; m_pc = 0; m_tgt = 0; m_sc = 0; m_fc = 0;
        end else begin
            go = 0;
            if (m_flush) begin
                m_flush = 0;
            end else if (exc) begin
                go = 1; m_cause = 0; m_pc = eret ? epc : VEC; m_pend = 0;
            end else if (m_pend) begin
                if (!es[1]) begin go = 1; m_cause = 1; m_pc = m_tgt; m_pend = 0; end
            end else if (misp) begin
                if (!es[1]) begin go = 1; m_cause = 1; m_pc = mtgt; end
                else begin m_pend = 1; m_tgt = mtgt; end
            end
            if (go) m_flush = 1;
            if (clr) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (es[0] && m_sc < (1 << SW) - 1) m_sc++;
                if (go && m_fc < (1 << FW) - 1) m_fc++;
            end
        end
        #1;
        chk("flush", {31'b0, flush}, {31'b0, m_flush});
        if (m_flush) chk("flush_cause", {31'b0, flush_cause}, {31'b0, m_cause});
        chk("new_pc", new_pc, m_pc);
        chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        chk("flush_count", 32'(flush_count), 32'(m_fc));
    endtask

    task automatic quiet();
        rst = 0; sid = 0; sex = 0; smem = 0; swb = 0;
        exc = 0; eret = 0; misp = 0; clr = 0;
    endtask

    initial begin
        m_flush = 0; m_cause = 0; m_pend = 0; m_pc = 0; m_tgt = 0; m_sc = 0; m_fc = 0;
        quiet(); epc = 0; mtgt = 0;

        // Reset with every stall request active.
        rst = 1; sid = 1; sex = 1; smem = 1; swb = 1;
        repeat (3) step();
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_flush_count", 32'(flush_count), 32'h0);

        // Stall priority.
        quiet(); sex = 1;
        step(); chk("stall_ex", {28'b0, stall}, 32'h3);
        smem = 1;
        step(); chk("stall_mem", {28'b0, stall}, 32'h7);
        quiet(); sid = 1;
        step(); chk("stall_id", {28'b0, stall}, 32'h1);
        chk("stall_cycles_3", 32'(stall_cycles), 32'd3);
        swb = 1;
        step(); chk("stall_wb", {28'b0, stall}, 32'hF);

        // Exception, then ERET.
        quiet(); step();
        exc = 1;
        step();
        chk("exc_flush", {31'b0, flush}, 32'h1);
        chk("exc_cause", {31'b0, flush_cause}, 32'h0);
        chk("exc_pc", new_pc, VEC);
        exc = 0;
        step(); chk("exc_one_cycle", {31'b0, flush}, 32'h0);
        exc = 1; eret = 1; epc = 32'h8000_1234;
        step(); chk("eret_pc", new_pc, 32'h8000_1234);
        quiet(); step();

        // Deferred misprediction behind an EX stall.
        clr = 1; step(); clr = 0;
        misp = 1; mtgt = 32'h8000_0100; sex = 1;
        step(); misp = 0;
        repeat (4) begin
            step(); chk("misp_held", {31'b0, flush}, 32'h0);
        end
        sex = 0;
        step();
        chk("misp_flush", {31'b0, flush}, 32'h1);
        chk("misp_cause", {31'b0, flush_cause}, 32'h1);
        chk("misp_pc", new_pc, 32'h8000_0100);
        chk("misp_count", 32'(flush_count), 32'd1);
        quiet(); step();

        // Collision: exception together with misprediction.
        clr = 1; step(); clr = 0;
        exc = 1; misp = 1; mtgt = 32'h8000_0200;
        step();
        chk("coll_cause", {31'b0, flush_cause}, 32'h0);
        quiet();
        repeat (3) begin
            step(); chk("coll_no_misp", {31'b0, flush}, 32'h0);
        end
        chk("coll_count", 32'(flush_count), 32'd1);

        // Exception during a pending misprediction.
        misp = 1; sex = 1; mtgt = 32'h8000_0300;
        step(); misp = 0;
        exc = 1;
        step(); exc = 0; sex = 0;
        chk("pend_exc_cause", {31'b0, flush_cause}, 32'h0);
        repeat (3) begin
            step(); chk("pend_dropped", {31'b0, flush}, 32'h0);
        end

        // Reset while pending drops the target.
        misp = 1; sex = 1; step(); misp = 0; sex = 0;
        rst = 1; step(); rst = 0;
        repeat (2) begin
            step(); chk("rst_drop", {31'b0, flush}, 32'h0);
        end

        // Saturation and clear against a flush.
        repeat (5) begin
            exc = 1; step(); exc = 0; step();
        end
        chk("fc_sat", 32'(flush_count), 32'd3);
        exc = 1; clr = 1;
        step();
        chk("clr_flush", {31'b0, flush}, 32'h1);
        chk("clr_count", 32'(flush_count), 32'd0);
        quiet(); step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 99) < 3);
            sid  = ($urandom_range(0, 99) < 25);
            sex  = ($urandom_range(0, 99) < 35);
            smem = ($urandom_range(0, 99) < 15);
            swb  = ($urandom_range(0, 99) < 8);
            exc  = ($urandom_range(0, 99) < 10);
            eret = $urandom_range(0, 1) == 1;
            misp = ($urandom_range(0, 99) < 25);
            clr  = ($urandom_range(0, 99) < 4);
            epc  = $urandom;
            mtgt = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline control for the dual-issue core. It drives the `stall[3:0]`, `flush`, `flush_cause` and `new_pc` signals consumed by the ID/EX, EX/MEM and MEM/WB pipeline registers and by the PC unit. It arbitrates stage stall requests, exceptions/ERET from MEM and branch mispredictions from EX. It defers a misprediction while EX is held, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380: general exception handler address.
- STALL_CNT_W, 32: width of the stall-cycle counter.
- FLUSH_CNT_W, 16: width of the flush counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_id  in  1  ID stage stall request.
- stallreq_ex  in  1  EX stall request (mul/div busy).
- stallreq_mem  in  1  MEM stall request (dcache miss).
- stallreq_wb  in  1  WB stall request.
- exc_valid  in  1  MEM-stage exception or ERET commit.
- exc_is_eret  in  1  qualifies exc_valid as ERET.
- cp0_epc  in  32  ERET return address.
- misp_valid  in  1  EX branch unit reports a misprediction.
- misp_target  in  32  corrected fetch address.
- clr_cnt  in  1  synchronous clear of both counters.
- stall  out  4  bit0 ID-side, bit1 EX, bit2 MEM, bit3 WB; 1 = hold stage (Stop).
- flush  out  1  one-cycle flush pulse.
- flush_cause  out  1  0 = Exception, 1 = FailedBranchPrediction.
- new_pc  out  32  redirect address, valid while flush=1.
- stall_cycles  out  STALL_CNT_W  cycles with stall[0]=1, saturating.
- flush_count  out  FLUSH_CNT_W  number of flush pulses, saturating.

## Operation
- Stall encoding is combinational from the requests. The highest requesting stage wins:
  - wb → 4'b1111
  - mem → 4'b0111
  - ex → 4'b0011
  - id → 4'b0001
  - none → 4'b0000
- stall is forced to 4'b0000 while rst=1 or flush=1.
- flush, flush_cause and new_pc are registered outputs.
- FSM states:
  - IDLE: no redirect pending.
  - MISP_PEND: a misprediction is latched and its target is held in an internal register.
  - FLUSH: the output pulse cycle; flush=1.
- Transitions, evaluated each edge, in priority order:
  - Any state except FLUSH, with exc_valid=1 → FLUSH.
    - flush_cause=0.
    - new_pc = cp0_epc if exc_is_eret, else EXC_VECTOR.
    - Any pending misprediction is discarded.
  - IDLE, misp_valid=1, combinational stall[1]=0 → FLUSH with flush_cause=1 and new_pc=misp_target.
  - IDLE, misp_valid=1, stall[1]=1 → MISP_PEND; latch misp_target.
  - MISP_PEND, stall[1]=0 → FLUSH with flush_cause=1 and new_pc=latched target.
    - A new misp_valid in MISP_PEND is ignored; the oldest branch wins.
  - MISP_PEND, stall[1]=1 → stay.
  - FLUSH → IDLE unconditionally.
    - exc_valid, misp_valid and all stallreq_* sampled during FLUSH are ignored; they belong to squashed instructions.
- new_pc holds its last value outside FLUSH.
- Counters:
  - stall_cycles increments each cycle stall[0]=1 and saturates at all-ones.
  - flush_count increments on each entry to FLUSH and saturates.
  - clr_cnt=1 zeroes both counters and takes priority over increment in the same cycle.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE, flush=0, flush_cause=0, new_pc=32'h0.
  - stall_cycles=0, flush_count=0, pending target=0.
  - stall reads 4'b0000 during rst.
- Exception latency: exc_valid at cycle N → flush=1 in cycle N+1, for exactly one cycle.
- Misprediction latency, no EX stall: misp_valid at N → flush in N+1.
- Misprediction with EX stall: flush lands in the cycle after the first cycle in which stall[1]=0.
- Simultaneous exc_valid and misp_valid: exception flush only; the misprediction is dropped.
- Back-to-back: the earliest second flush is in cycle N+3, because inputs in the FLUSH cycle are ignored.
- rst asserted in MISP_PEND or FLUSH: the pending target is dropped and no flush is emitted afterward.

## Test plan
- Reset: hold rst 3 cycles with all stallreq=1 → stall=0000, flush=0, new_pc=0, counters=0.
- Stall priority:
  - stallreq_ex=1 alone → stall=0011.
  - add stallreq_mem → 0111.
  - stallreq_id alone → 0001.
  - stall_cycles counts 3 after 3 such cycles.
- Exception: exc_valid=1, exc_is_eret=0 at cycle 10 → flush=1, flush_cause=0, new_pc=BFC00380 in cycle 11 only; then exc_is_eret=1, cp0_epc=80001234 → new_pc=80001234.
- Deferred misprediction: misp_valid=1, misp_target=80000100 with stallreq_ex=1 held for cycles 20-24 → no flush until cycle 26; then flush=1, flush_cause=1, new_pc=80000100, flush_count=1.
- Collision: misp_valid and exc_valid together (or exc_valid during MISP_PEND) → a single flush with cause 0; no later misprediction flush; flush_count increments by 1.
- Saturation/clear: preload flush_count near FFFF by forcing 70000 flushes (or use FLUSH_CNT_W=2) → sticks at max; clr_cnt asserted on the same cycle as a flush → counter=0.
